pre_ce_sequencer: RTL and testbench
===================================

// Module: pre_ce_sequencer
// PURPOSE
//  Upstream control stage for banks of FDPE flops. Generates per-group PRE (async preset)
//  and CE (clock enable) strobes. Presets assert asynchronously on CLR. Groups are released
//  synchronously, in order, after a hold period. Once a group is out of preset, its CE runs
//  at a programmable division of C.
// PARAMETERS
//  NUM_GRP       4     number of FDPE groups driven (1..16)
//  SYNC_STAGES   2     CLR deassertion synchroniser depth (2..4)
//  HOLD_CYCLES   16    edges from HOLD entry to PRE[0] release (1..65535)
//  GAP_CYCLES    2     edges between consecutive group releases (0 = all groups together)
//  CE_DIV        1     CE strobe period in edges (1 = CE continuous)
//  IS_C_INVERTED 1'b0  1 = all state updates on negedge C
// PORTS
//  C       in   1        clock
//  CLR     in   1        asynchronous reset, active-high
//  SRST    in   1        synchronous restart request, active-high
//  CE_EN   in   1        global CE gate; combinational into CE
//  PRE     out  NUM_GRP  preset per group, active-high
//  CE      out  NUM_GRP  clock enable per group
//  DONE    out  1        all groups released
//  STATE   out  2        0 RESET, 1 HOLD, 2 RELEASE, 3 RUN
// BEHAVIOUR
//  - One clock C. Reset CLR is asynchronous and active-high.
//  - CLR high, immediately and independent of C:
//    PRE = all 1s, CE = 0, DONE = 0, STATE = RESET, counters = 0, sync chain = all 1s.
//  - CLR fall: 1s drain through the sync chain. rst_s goes low SYNC_STAGES edges later.
//  - RESET -> HOLD on the first edge that samples rst_s = 0. Call that edge E0.
//  - PRE[0] falls on edge E0+HOLD_CYCLES.
//  - PRE[g] falls on edge E0+HOLD_CYCLES+g*GAP_CYCLES.
//  - STATE = RELEASE while some PRE bits are still high. It becomes RUN, and DONE rises,
//    on the edge PRE[NUM_GRP-1] falls.
//  - GAP_CYCLES = 0: all PRE bits fall together; HOLD goes straight to RUN.
//  - PRE bits are released in strict order. No PRE bit ever re-asserts except via CLR or SRST.
//  - CE phase counter (0..CE_DIV-1):
//    - cleared on the edge PRE[0] falls;
//    - increments mod CE_DIV each edge in RELEASE and RUN;
//    - held at 0 in RESET and HOLD;
//    - tick = (phase == 0).
//  - CE[g] = tick & ~PRE[g] & CE_EN. CE_EN is the only combinational path to any output.
//  - CE_DIV = 1: CE[g] = ~PRE[g] & CE_EN.
//  - SRST sampled high in HOLD, RELEASE or RUN:
//    - that edge becomes a new E0: PRE = all 1s, DONE = 0, STATE = HOLD, counters = 0;
//    - SRST held high keeps the hold counter at 0;
//    - the release schedule restarts from the last edge that sampled SRST high.
//  - SRST in RESET is ignored. CLR has priority over SRST at all times.
//  - CLR asserted mid-sequence: PRE returns to all 1s asynchronously, with no glitch to 0 on any bit.
//  - Hold/gap counter width: clog2(max(HOLD_CYCLES, GAP_CYCLES)+1). Counters saturate; no wrap.
//  - All outputs except CE are driven directly from flops.
// STRUCTURE
//  - Package pre_ce_seq_pkg:
//    - state localparams ST_RESET/ST_HOLD/ST_RELEASE/ST_RUN (2 bits);
//    - clog2 function.
//  - Sub-module rst_sync_chain (params SYNC_STAGES, IS_C_INVERTED):
//    async-assert / sync-deassert chain turning CLR into rst_s.
//  - Top: 2-bit FSM, hold/gap down-counter, group index, PRE shift-release register,
//    CE phase counter.
//  - Clock polarity is selected by a generate branch (posedge/negedge) around a shared body.
// TESTING
//  1. Defaults. CLR pulse, then release.
//     -> PRE[0..3] fall on edges 19/21/23/25 after CLR fall; DONE and STATE = 3 at edge 25;
//        CE = PRE complement.
//  2. CE_DIV = 4, CE_EN = 1.
//     -> CE[g] high exactly 1 of every 4 edges; first strobe on the cycle after PRE[0] falls.
//        CE_EN = 0 forces CE = 0 the same cycle.
//  3. SRST pulse at edge 22 (PRE[0..1] released).
//     -> edge 22 returns PRE = 4'hF, DONE = 0, STATE = 1; PRE[0] falls at edge 38.
//  4. CLR asserted asynchronously mid-RELEASE, between edges.
//     -> PRE = 4'hF, CE = 0, STATE = 0 before the next edge; full schedule on release.
//  5. GAP_CYCLES = 0, HOLD_CYCLES = 1.
//     -> all PRE fall together on edge 4 after CLR fall; STATE goes HOLD -> RUN directly.
//  6. IS_C_INVERTED = 1, repeat test 1 on negedges.
//     -> identical edge counts; no output changes on posedge C.

Source files
------------

// File: rtl/pre_ce_seq_pkg.sv
// Shared types and helpers for the PRE/CE sequencer.
package pre_ce_seq_pkg;

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } seq_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Async-assert / sync-deassert reset chain: CLR forces rst_s high at once,
// its release drains through SYNC_STAGES flops on the active C edge.
module rst_sync_chain #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic        IS_C_INVERTED = 1'b0
) (
  input  logic C,
  input  logic CLR,
  output logic rst_s
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift zeros in from the bottom once CLR is low.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  generate
    if (IS_C_INVERTED) begin : g_neg
      // Chain registers on the falling edge of C.
      always_ff @(negedge C or posedge CLR) begin
        if (CLR) sync_q <= '1;
        else     sync_q <= sync_d;
      end
    end else begin : g_pos
      // Chain registers on the rising edge of C.
      always_ff @(posedge C or posedge CLR) begin
        if (CLR) sync_q <= '1;
        else     sync_q <= sync_d;
      end
    end
  endgenerate

  assign rst_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pre_ce_sequencer.sv
// Upstream control for banks of FDPE flops: holds every group in preset after
// reset, then releases the groups in order and strobes their clock enables.
module pre_ce_sequencer #(
  parameter int unsigned NUM_GRP       = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned GAP_CYCLES    = 2,
  parameter int unsigned CE_DIV        = 1,
  parameter logic        IS_C_INVERTED = 1'b0
) (
  input  logic               C,
  input  logic               CLR,
  input  logic               SRST,
  input  logic               CE_EN,
  output logic [NUM_GRP-1:0] PRE,
  output logic [NUM_GRP-1:0] CE,
  output logic               DONE,
  output logic [1:0]         STATE
);

  import pre_ce_seq_pkg::*;

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = clog2(CNT_MAX + 1);
  localparam int unsigned PH_W    = (CE_DIV > 1) ? clog2(CE_DIV) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(CE_DIV - 1);

  logic                 rst_s;
  seq_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_GRP-1:0]   pre_q, pre_d;
  logic                 done_q, done_d;
  logic [PH_W-1:0]      phase_q, phase_d;

  logic [NUM_GRP-1:0]   pre_shift;
  logic [NUM_GRP-1:0]   pre_first;
  logic [PH_W-1:0]      phase_next;
  logic                 tick;

  rst_sync_chain #(
    .SYNC_STAGES   (SYNC_STAGES),
    .IS_C_INVERTED (IS_C_INVERTED)
  ) u_rst_sync (
    .C     (C),
    .CLR   (CLR),
    .rst_s (rst_s)
  );

  // Release helpers: a left shift clears the lowest still-set PRE bit, so
  // groups can only ever leave preset in ascending order.
  always_comb begin
    pre_shift  = pre_q << 1;
    pre_first  = (GAP_CYCLES == 0) ? '0 : pre_shift;
    phase_next = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
  end

  // Sequencer next state: restart, hold count, staggered release, CE phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    done_d  = done_q;
    phase_d = phase_q;
    if ((state_q != ST_RESET) && SRST) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      pre_d   = '1;
      done_d  = 1'b0;
      phase_d = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (!rst_s) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d   = '0;
            phase_d = '0;
            pre_d   = pre_first;
            if (pre_first == '0) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          phase_d = phase_next;
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            pre_d = pre_shift;
            if (pre_shift == '0) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          phase_d = phase_next;
        end
        default: begin
          state_d = ST_RESET;
        end
      endcase
    end
  end

  // Same register body on either edge of C; CLR presets asynchronously.
  generate
    if (IS_C_INVERTED) begin : g_neg
      // Sequencer state on the falling edge of C.
      always_ff @(negedge C or posedge CLR) begin
        if (CLR) begin
          state_q <= ST_RESET;
          cnt_q   <= '0;
          pre_q   <= '1;
          done_q  <= 1'b0;
          phase_q <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          pre_q   <= pre_d;
          done_q  <= done_d;
          phase_q <= phase_d;
        end
      end
    end else begin : g_pos
      // Sequencer state on the rising edge of C.
      always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
          state_q <= ST_RESET;
          cnt_q   <= '0;
          pre_q   <= '1;
          done_q  <= 1'b0;
          phase_q <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          pre_q   <= pre_d;
          done_q  <= done_d;
          phase_q <= phase_d;
        end
      end
    end
  endgenerate

  assign tick  = (phase_q == '0);
  assign CE    = ~pre_q & {NUM_GRP{tick & CE_EN}};
  assign PRE   = pre_q;
  assign DONE  = done_q;
  assign STATE = state_q;

endmodule

// File: tb/tb_pre_ce_sequencer.sv
// Randomized bench for pre_ce_sequencer: four parameterisations driven by the
// same stimulus, each compared against an edge-count reference model.
module tb_pre_ce_sequencer;

  localparam int NI  = 4;
  localparam int P_N = 4;
  localparam int P_S [NI] = '{2, 3, 2, 2};
  localparam int P_H [NI] = '{16, 5, 1, 16};
  localparam int P_G [NI] = '{2, 3, 0, 2};
  localparam int P_D [NI] = '{1, 4, 1, 1};

  logic C = 1'b0;
  logic CLR, SRST, CE_EN;

  logic [3:0] pre_o  [NI];
  logic [3:0] ce_o   [NI];
  logic       done_o [NI];
  logic [1:0] st_o   [NI];

  // Model: edges since the current E0 (-1 = in RESET) and CLR-drain edges.
  int since [NI];
  int drain [NI];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 C = ~C;

  pre_ce_sequencer #(
    .NUM_GRP(4), .SYNC_STAGES(2), .HOLD_CYCLES(16), .GAP_CYCLES(2),
    .CE_DIV(1), .IS_C_INVERTED(1'b0)
  ) u_dut0 (
    .C(C), .CLR(CLR), .SRST(SRST), .CE_EN(CE_EN),
    .PRE(pre_o[0]), .CE(ce_o[0]), .DONE(done_o[0]), .STATE(st_o[0])
  );

  pre_ce_sequencer #(
    .NUM_GRP(4), .SYNC_STAGES(3), .HOLD_CYCLES(5), .GAP_CYCLES(3),
    .CE_DIV(4), .IS_C_INVERTED(1'b0)
  ) u_dut1 (
    .C(C), .CLR(CLR), .SRST(SRST), .CE_EN(CE_EN),
    .PRE(pre_o[1]), .CE(ce_o[1]), .DONE(done_o[1]), .STATE(st_o[1])
  );

  pre_ce_sequencer #(
    .NUM_GRP(4), .SYNC_STAGES(2), .HOLD_CYCLES(1), .GAP_CYCLES(0),
    .CE_DIV(1), .IS_C_INVERTED(1'b0)
  ) u_dut2 (
    .C(C), .CLR(CLR), .SRST(SRST), .CE_EN(CE_EN),
    .PRE(pre_o[2]), .CE(ce_o[2]), .DONE(done_o[2]), .STATE(st_o[2])
  );

  pre_ce_sequencer #(
    .NUM_GRP(4), .SYNC_STAGES(2), .HOLD_CYCLES(16), .GAP_CYCLES(2),
    .CE_DIV(1), .IS_C_INVERTED(1'b1)
  ) u_dut3 (
    .C(C), .CLR(CLR), .SRST(SRST), .CE_EN(CE_EN),
    .PRE(pre_o[3]), .CE(ce_o[3]), .DONE(done_o[3]), .STATE(st_o[3])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Expected outputs from the release schedule: group g leaves preset at
  // E0 + H + g*G, CE strobes every D edges counted from PRE[0] release.
  function automatic void model_out(input int i, output logic [3:0] pre,
                                    output logic [3:0] ce, output logic done,
                                    output logic [1:0] st);
    int e;
    logic tick;
    e    = since[i];
    pre  = '1;
    ce   = '0;
    done = 1'b0;
    st   = 2'd0;
    if (!CLR && e >= 0) begin
      for (int g = 0; g < P_N; g++) pre[g] = (e < P_H[i] + g * P_G[i]);
      if (e < P_H[i])                              st = 2'd1;
      else if (e >= P_H[i] + (P_N - 1) * P_G[i])  st = 2'd3;
      else                                         st = 2'd2;
      done = (st == 2'd3);
      tick = (e >= P_H[i]) && (((e - P_H[i]) % P_D[i]) == 0);
      for (int g = 0; g < P_N; g++) ce[g] = tick && !pre[g] && CE_EN;
    end
  endfunction

  task automatic check_all();
    logic [3:0] ep, ec;
    logic       ed;
    logic [1:0] es;
    for (int i = 0; i < NI; i++) begin
      model_out(i, ep, ec, ed, es);
      chk($sformatf("c%0d u%0d PRE", cyc, i),   32'(pre_o[i]),  32'(ep));
      chk($sformatf("c%0d u%0d CE", cyc, i),    32'(ce_o[i]),   32'(ec));
      chk($sformatf("c%0d u%0d DONE", cyc, i),  32'(done_o[i]), 32'(ed));
      chk($sformatf("c%0d u%0d STATE", cyc, i), 32'(st_o[i]),   32'(es));
    end
  endtask

  // Advance every model by one active edge using the inputs now applied.
  task automatic advance();
    for (int i = 0; i < NI; i++) begin
      if (CLR) begin
        since[i] = -1;
        drain[i] = 0;
      end else if (since[i] < 0) begin
        if (drain[i] >= P_S[i]) since[i] = 0;
        else                    drain[i]++;
      end else if (SRST) begin
        since[i] = 0;
      end else if (since[i] < 1000000) begin
        since[i]++;
      end
    end
  endtask

  // One cycle: check the negedge instance between edges (before posedge),
  // drive inputs mid-cycle, check every instance, then advance the models.
  task automatic step(input logic clr_v, input logic srst_v, input logic ce_en_v);
    logic [3:0] ep, ec;
    logic       ed;
    logic [1:0] es;
    @(negedge C);
    #3;
    model_out(3, ep, ec, ed, es);
    chk($sformatf("c%0d u3 PRE pre-posedge", cyc),   32'(pre_o[3]),  32'(ep));
    chk($sformatf("c%0d u3 STATE pre-posedge", cyc), 32'(st_o[3]),   32'(es));
    chk($sformatf("c%0d u3 DONE pre-posedge", cyc),  32'(done_o[3]), 32'(ed));
    #4;
    CLR   = clr_v;
    SRST  = srst_v;
    CE_EN = ce_en_v;
    #1;
    check_all();
    advance();
    cyc++;
  endtask

  initial begin
    CLR   = 1'b1;
    SRST  = 1'b0;
    CE_EN = 1'b0;
    for (int i = 0; i < NI; i++) begin
      since[i] = -1;
      drain[i] = 0;
    end

    // Reset, release, and a restart sampled on edge 22 after CLR fall.
    repeat (3) step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 60; k++) step(1'b0, k == 21, 1'b1);

    // CLR raised between edges while groups are mid-release, then a full
    // schedule with SRST held for several cycles and CE_EN toggling.
    repeat (2) step(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 21; k++) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 70; k++)
      step(1'b0, (k >= 30) && (k < 35), $urandom_range(0, 3) != 0);

    // Random mixes of CLR, SRST and CE_EN.
    for (int r = 0; r < 6; r++) begin
      step(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 50; k++)
        step($urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0,
             $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
